analog_channel_scan_scheduler: RTL and testbench



---
 rtl/analog_channel_scan_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_analog_channel_scan_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_channel_scan_scheduler.sv
// analog_channel_scan_scheduler
//   Round-robin scanner that shares one ADC across NUM_CH analog channels.
//   For each channel it drives the mux select, waits a programmable settle
//   time, pulses a conversion start and captures the result. A completed
//   frame is copied atomically into the SAMPLE[] shadow registers.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   address    Avalon-MM word address
//   read       Avalon-MM read strobe (readdata is refreshed every cycle)
//   write      Avalon-MM write strobe
//   writedata  Avalon-MM write data
//   readdata   Avalon-MM read data, registered (valid one cycle after address)
//   adc_sel    analog mux channel select
//   adc_start  one-cycle conversion trigger
//   adc_done   conversion complete, adc_data valid in the same cycle
//   adc_data   conversion result
//   irq        frame-ready interrupt, level (frame_ready & irq_en)
//
// Register map: 0 CTRL, 1 STATUS, 2 FRAME_CNT, 4.. SAMPLE[n]; others read 0.
module analog_channel_scan_scheduler #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [2:0]        adc_sel,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              irq
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        STORE,
        COMMIT
    } state_t;

    state_t            state;
    logic [2:0]        ch;
    logic [7:0]        settle_cnt;

    logic              enable;
    logic              continuous;
    logic              irq_en;
    logic [7:0]        settle;
    logic              frame_ready;
    logic              overrun;
    logic [15:0]       frame_cnt;
    logic [DATA_W-1:0] working [NUM_CH];
    logic [DATA_W-1:0] sample  [NUM_CH];

    logic              ctrl_wr;
    logic              status_wr;
    logic              en_eff;
    logic              cont_eff;
    logic [7:0]        settle_eff;
    logic              busy;
    logic [31:0]       rd_mux;
    logic              unused;

    assign ctrl_wr   = write && (address == 4'd0);
    assign status_wr = write && (address == 4'd1);

    // A CTRL write in this cycle already governs the transition taken at this
    // edge, so an enable clear aborts immediately and a new settle value is
    // picked up by a SELECT entered at the same edge.
    assign en_eff     = ctrl_wr ? writedata[0]    : enable;
    assign cont_eff   = ctrl_wr ? writedata[1]    : continuous;
    assign settle_eff = ctrl_wr ? writedata[15:8] : settle;

    assign busy = (state != IDLE);
    assign irq  = frame_ready & irq_en;

    assign unused = ^{read, writedata[31:16], writedata[7:3]};

    always_comb begin
        rd_mux = '0;
        case (address)
            4'd0:    rd_mux = {16'd0, settle, 5'd0, irq_en, continuous, enable};
            4'd1:    rd_mux = {29'd0, busy, overrun, frame_ready};
            4'd2:    rd_mux = {16'd0, frame_cnt};
            default: begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (address == 4'(4 + n))
                        rd_mux = 32'(sample[n]);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            settle_cnt  <= '0;
            enable      <= 1'b0;
            continuous  <= 1'b0;
            irq_en      <= 1'b0;
            settle      <= '0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
            readdata    <= '0;
            adc_sel     <= '0;
            adc_start   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                working[i] <= '0;
                sample[i]  <= '0;
            end
        end else begin
            readdata  <= rd_mux;
            adc_start <= 1'b0;

            if (ctrl_wr) begin
                enable     <= writedata[0];
                continuous <= writedata[1];
                irq_en     <= writedata[2];
                settle     <= writedata[15:8];
            end
            if (status_wr) begin
                if (writedata[0]) frame_ready <= 1'b0;
                if (writedata[1]) overrun     <= 1'b0;
            end

            if (state != IDLE && !en_eff) begin
                // Abort: partial frame is dropped, shadow registers untouched.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (en_eff) begin
                            ch         <= '0;
                            adc_sel    <= '0;
                            settle_cnt <= settle_eff;
                            state      <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (settle_cnt == 8'd0) begin
                            adc_start <= 1'b1;
                            state     <= START;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    START: state <= WAIT;
                    WAIT: begin
                        if (adc_done) begin
                            working[ch] <= adc_data;
                            state       <= STORE;
                        end
                    end
                    STORE: begin
                        if (ch == 3'(NUM_CH - 1)) begin
                            state <= COMMIT;
                        end else begin
                            ch         <= ch + 3'd1;
                            adc_sel    <= ch + 3'd1;
                            settle_cnt <= settle_eff;
                            state      <= SELECT;
                        end
                    end
                    COMMIT: begin
                        sample    <= working;
                        frame_cnt <= frame_cnt + 16'd1;
                        if (frame_ready) overrun <= 1'b1;
                        // Placed after the STATUS write so the set wins a W1C race.
                        frame_ready <= 1'b1;
                        if (cont_eff) begin
                            ch         <= '0;
                            adc_sel    <= '0;
                            settle_cnt <= settle_eff;
                            state      <= SELECT;
                        end else begin
                            enable <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_analog_channel_scan_scheduler.sv
// tb_analog_channel_scan_scheduler
//   Directed bench for analog_channel_scan_scheduler with a behavioural ADC
//   that raises adc_done three cycles after each start, data = base + channel.
module tb_analog_channel_scan_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [2:0]  adc_sel;
    logic        adc_start;
    logic        adc_done;
    logic [7:0]  adc_data;
    logic        irq;

    logic [7:0]  base;
    int          vectors;
    int          miscompares;

    analog_channel_scan_scheduler #(
        .NUM_CH(6),
        .DATA_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .adc_sel   (adc_sel),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        d       = readdata;
    endtask

    // ADC model: start seen at negedge t+0.5, done high for the cycle
    // t+3.5..t+4.5, giving three WAIT cycles.
    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                repeat (3) @(negedge clk);
                adc_data = base + 8'(adc_sel);
                adc_done = 1'b1;
                @(negedge clk);
                adc_done = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] d;
        int n;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        address     = '0;
        read        = 1'b0;
        write       = 1'b0;
        writedata   = '0;
        base        = 8'h10;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_adc_sel", 32'(adc_sel), 32'h0);
        check("rst_adc_start", 32'(adc_start), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd(4'd0, d); check("rst_ctrl", d, 32'h0);
        rd(4'd1, d); check("rst_status", d, 32'h0);
        rd(4'd2, d); check("rst_frame_cnt", d, 32'h0);
        rd(4'd4, d); check("rst_sample0", d, 32'h0);

        // Single-shot scan, settle 2: 6 x 8 + 1 = 49 frame cycles,
        // plus one cycle for the registered STATUS read.
        base = 8'h10;
        wr(4'd0, 32'h0000_0201);
        address = 4'd1;
        n = 0;
        while (readdata[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("single_frame_cycles", 32'(n), 32'd50);
        check("single_irq_masked", 32'(irq), 32'h0);
        rd(4'd1, d); check("single_status", d, 32'h1);
        rd(4'd2, d); check("single_frame_cnt", d, 32'h1);
        rd(4'd0, d); check("single_enable_cleared", d, 32'h0000_0200);
        for (int i = 0; i < 6; i++) begin
            rd(4'(4 + i), d);
            check($sformatf("single_sample%0d", i), d, 32'h10 + 32'(i));
        end
        rd(4'd3, d);  check("unmapped_addr3", d, 32'h0);
        rd(4'd10, d); check("unmapped_addr10", d, 32'h0);
        wr(4'd3, 32'hFFFF_FFFF);
        rd(4'd3, d);  check("unmapped_write_ignored", d, 32'h0);

        // W1C clear, then W1C coinciding with COMMIT: set wins
        wr(4'd1, 32'h1);
        rd(4'd1, d); check("w1c_clear", d, 32'h0);
        base = 8'h30;
        wr(4'd0, 32'h0000_0001);
        n = 0;
        while (!(adc_start === 1'b1 && adc_sel === 3'd5) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("race_found_last_start", 32'(n < 400), 32'h1);
        // START at t; done sampled t+4, STORE, COMMIT during t+5..t+6
        repeat (5) @(negedge clk);
        address   = 4'd1;
        writedata = 32'h1;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        rd(4'd1, d); check("race_set_wins", d, 32'h1);
        rd(4'd2, d); check("race_frame_cnt", d, 32'h2);
        rd(4'd6, d); check("race_sample2", d, 32'h32);

        // Abort while in WAIT on channel 3
        base = 8'h50;
        wr(4'd0, 32'h0000_0001);
        n = 0;
        while (!(adc_start === 1'b1 && adc_sel === 3'd3) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_found_ch3_start", 32'(n < 400), 32'h1);
        @(negedge clk);
        address   = 4'd0;
        writedata = 32'h0;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        address   = 4'd1;
        @(negedge clk);
        check("abort_not_busy", readdata, 32'h1);
        repeat (60) @(negedge clk);
        rd(4'd2, d); check("abort_frame_cnt", d, 32'h2);
        rd(4'd4, d); check("abort_sample0", d, 32'h30);
        rd(4'd7, d); check("abort_sample3", d, 32'h33);
        rd(4'd1, d); check("abort_status_idle", d, 32'h1);

        // FRAME_CNT wrap
        wr(4'd1, 32'h3);
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        rd(4'd2, d); check("wrap_preload", d, 32'hFFFF);
        base = 8'h60;
        wr(4'd0, 32'h0000_0001);
        address = 4'd1;
        n = 0;
        while (readdata[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wrap_frame_done", 32'(n < 200), 32'h1);
        rd(4'd2, d); check("wrap_frame_cnt", d, 32'h0);
        rd(4'd9, d); check("wrap_sample5", d, 32'h65);

        // Continuous with overrun, STATUS never cleared after start
        wr(4'd1, 32'h3);
        base = 8'h20;
        wr(4'd0, 32'h0000_0007);
        address = 4'd2;
        n = 0;
        while (readdata !== 32'h1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cont_frame1", 32'(n < 200), 32'h1);
        base = 8'h40;
        check("cont_irq_frame1", 32'(irq), 32'h1);
        n = 0;
        while (readdata !== 32'h2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cont_frame2", 32'(n < 200), 32'h1);
        rd(4'd1, d); check("cont_overrun_status", d, 32'h7);
        check("cont_irq_frame2", 32'(irq), 32'h1);
        rd(4'd4, d); check("cont_sample0", d, 32'h40);
        rd(4'd9, d); check("cont_sample5", d, 32'h45);

        // Synchronous reset during START
        n = 0;
        while (adc_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst2_found_start", 32'(n < 100), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_adc_start", 32'(adc_start), 32'h0);
        check("rst2_irq", 32'(irq), 32'h0);
        check("rst2_adc_sel", 32'(adc_sel), 32'h0);
        check("rst2_readdata", readdata, 32'h0);
        rd(4'd0, d); check("rst2_ctrl", d, 32'h0);
        rd(4'd2, d); check("rst2_frame_cnt", d, 32'h0);
        rd(4'd4, d); check("rst2_sample0", d, 32'h0);
        repeat (10) @(negedge clk);
        rd(4'd1, d); check("rst2_status_idle", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
